// File: rtl/mem_lsu_stage_pkg.sv
// Shared constants for the MEM/LSU stage: opcodes, access sizes,
// exception cause codes and FSM state encodings.
package mem_lsu_stage_pkg;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;

    // func3[1:0] access size; func3[2] selects zero-extension on loads
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LD) || (op == OP_S);
    endfunction

endpackage

// File: rtl/mem_lsu_stage_if.sv
// Data-memory valid/ready bus between the LSU (master) and memory (slave).
interface mem_lsu_stage_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int SEL_W = XLEN / 8;

    logic              o_wr_en;
    logic [SEL_W-1:0]  o_sel;
    logic [ADDR_W-1:0] o_daddr;
    logic [XLEN-1:0]   o_write_data;
    logic              o_d_ready;
    logic [XLEN-1:0]   i_read_data;
    logic              i_d_valid;
    logic              i_error;

    modport master (
        output o_wr_en, o_sel, o_daddr, o_write_data, o_d_ready,
        input  i_read_data, i_d_valid, i_error
    );

    modport slave (
        input  o_wr_en, o_sel, o_daddr, o_write_data, o_d_ready,
        output i_read_data, i_d_valid, i_error
    );

endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane helper: store replication and byte enables, load extract and
// sign/zero extension, misalignment detection. Purely combinational.
module mem_lsu_align
    import mem_lsu_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = XLEN / 8,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [OFF_W-1:0] off_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [XLEN-1:0]  store_data_i,
    input  logic [XLEN-1:0]  read_data_i,
    output logic [SEL_W-1:0] sel_o,
    output logic [XLEN-1:0]  write_data_o,
    output logic [XLEN-1:0]  load_data_o,
    output logic             misaligned_o
);

    logic [SEL_W-1:0] mask;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  keep;
    logic             sign;

    assign shifted = read_data_i >> {off_i, 3'b000};

    // Size decode drives lane mask, kept load bits, sign bit and store replication
    always_comb begin
        mask         = '0;
        keep         = '0;
        sign         = 1'b0;
        write_data_o = store_data_i;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_B: begin
                mask         = SEL_W'(1);
                keep         = XLEN'(8'hFF);
                sign         = shifted[7];
                write_data_o = {SEL_W{store_data_i[7:0]}};
            end
            SZ_H: begin
                mask         = SEL_W'(2'b11);
                keep         = XLEN'(16'hFFFF);
                sign         = shifted[15];
                write_data_o = {(XLEN/16){store_data_i[15:0]}};
                misaligned_o = off_i[0];
            end
            SZ_W: begin
                mask         = SEL_W'(4'hF);
                keep         = XLEN'(32'hFFFF_FFFF);
                sign         = shifted[31];
                write_data_o = {(XLEN/32){store_data_i[31:0]}};
                misaligned_o = |off_i[1:0];
            end
            default: begin
                // double-word only exists on a 64-bit datapath
                mask         = '1;
                keep         = '1;
                sign         = shifted[XLEN-1];
                misaligned_o = (XLEN != 64) || (|off_i);
            end
        endcase
        sel_o       = mask << off_i;
        load_data_o = (shifted & keep) | ({XLEN{sign & ~unsigned_i}} & ~keep);
    end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage with multi-cycle data-memory access, lane alignment,
// load extension, misalign/bus-fault exceptions and registered WB outputs.
// Optional wait timeout enabled by defining MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | accepting; pass-through or issue a memory request
// WAIT  | request outstanding, bus outputs held, upstream stalled
// DONE  | response registered into WB; accepts like IDLE
module mem_lsu_stage
    import mem_lsu_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [XLEN-1:0]   i_result,
    input  logic [XLEN-1:0]   i_data_store,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_func3,
    input  logic [4:0]        i_rd,
    output logic              o_stall,
    output logic [4:0]        o_ex_rd,
    output logic              o_wb_valid,
    output logic [4:0]        o_wb_rd,
    output logic [XLEN-1:0]   o_wb_data,
    output logic [6:0]        o_opcode,
    output logic              o_exc,
    output logic [3:0]        o_exc_cause,
    output logic [ADDR_W-1:0] o_exc_pc,
    mem_lsu_stage_if.master   dbus
);

    localparam int SEL_W = XLEN / 8;
    localparam int OFF_W = $clog2(SEL_W);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("mem_lsu_stage: XLEN must be 32 or 64");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_lsu_stage: TIMEOUT must be at least 1");
    end

    logic [1:0]        state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [6:0]        op_q, op_d;

    logic              wr_en_q, wr_en_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              d_ready_q, d_ready_d;

    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [6:0]        wb_op_q, wb_op_d;
    logic              exc_q, exc_d;
    logic [3:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] exc_pc_q, exc_pc_d;

    logic              busy, is_mem, is_store_in, accept, timeout_hit;
    logic [OFF_W-1:0]  off_in;
    logic [ADDR_W-1:0] addr_in, addr_aligned;
    logic [SEL_W-1:0]  al_sel;
    logic [XLEN-1:0]   al_wdata, al_load;
    logic              al_mis;

    assign busy         = (state_q == ST_WAIT);
    assign is_mem       = i_valid && is_mem_op(i_opcode) && !busy;
    assign is_store_in  = (i_opcode == OP_S);
    assign off_in       = i_result[OFF_W-1:0];
    assign addr_in      = ADDR_W'(i_result);
    assign addr_aligned = addr_in & ~ADDR_W'(SEL_W - 1);
    assign accept       = is_mem && !al_mis;

    // One aligner serves both directions: live request fields when idle,
    // latched fields while the response is awaited.
    mem_lsu_align #(.XLEN(XLEN), .SEL_W(SEL_W), .OFF_W(OFF_W)) u_align (
        .off_i        (busy ? off_q : off_in),
        .size_i       (busy ? size_q : i_func3[1:0]),
        .unsigned_i   (busy ? uns_q : i_func3[2]),
        .store_data_i (i_data_store),
        .read_data_i  (dbus.i_read_data),
        .sel_o        (al_sel),
        .write_data_o (al_wdata),
        .load_data_o  (al_load),
        .misaligned_o (al_mis)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d       = busy ? cnt_q + CNT_W'(1) : '0;
    assign timeout_hit = busy && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Cycles spent in WAIT; cleared whenever no request is outstanding
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state: request issue, response capture, WB/exception staging
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        op_d       = op_q;
        wr_en_d    = wr_en_q;
        sel_d      = sel_q;
        daddr_d    = daddr_q;
        wdata_d    = wdata_q;
        d_ready_d  = d_ready_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_op_d    = wb_op_q;
        exc_d      = 1'b0;
        cause_d    = cause_q;
        exc_pc_d   = exc_pc_q;

        if (busy) begin
            // a response in the expiry cycle takes priority over the timeout
            if (dbus.i_d_valid || timeout_hit) begin
                state_d   = ST_DONE;
                d_ready_d = 1'b0;
                wr_en_d   = 1'b0;
                sel_d     = '0;
                wb_rd_d   = rd_q;
                wb_op_d   = op_q;
                if (dbus.i_error || !dbus.i_d_valid) begin
                    exc_d    = 1'b1;
                    cause_d  = is_store_q ? EXC_ST_FAULT : EXC_LD_FAULT;
                    exc_pc_d = pc_q;
                end else if (!is_store_q) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = al_load;
                end
            end
        end else begin
            state_d   = ST_IDLE;
            d_ready_d = 1'b0;
            wr_en_d   = 1'b0;
            sel_d     = '0;
            if (i_valid) begin
                wb_rd_d = i_rd;
                wb_op_d = i_opcode;
                if (!is_mem_op(i_opcode)) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = i_result;
                end else if (al_mis) begin
                    exc_d    = 1'b1;
                    cause_d  = is_store_in ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                    exc_pc_d = i_pc;
                end else begin
                    state_d    = ST_WAIT;
                    is_store_d = is_store_in;
                    size_d     = i_func3[1:0];
                    uns_d      = i_func3[2];
                    off_d      = off_in;
                    rd_d       = i_rd;
                    pc_d       = i_pc;
                    op_d       = i_opcode;
                    d_ready_d  = 1'b1;
                    wr_en_d    = is_store_in;
                    sel_d      = al_sel;
                    daddr_d    = addr_aligned;
                    wdata_d    = al_wdata;
                end
            end
        end
    end

    // State and output registers; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            rd_q       <= '0;
            pc_q       <= '0;
            op_q       <= '0;
            wr_en_q    <= 1'b0;
            sel_q      <= '0;
            daddr_q    <= '0;
            wdata_q    <= '0;
            d_ready_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_op_q    <= '0;
            exc_q      <= 1'b0;
            cause_q    <= '0;
            exc_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            wr_en_q    <= wr_en_d;
            sel_q      <= sel_d;
            daddr_q    <= daddr_d;
            wdata_q    <= wdata_d;
            d_ready_q  <= d_ready_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_op_q    <= wb_op_d;
            exc_q      <= exc_d;
            cause_q    <= cause_d;
            exc_pc_q   <= exc_pc_d;
        end
    end

    assign o_stall   = busy || accept;
    assign o_ex_rd   = busy ? rd_q : (i_valid ? i_rd : 5'd0);

    assign o_wb_valid  = wb_valid_q;
    assign o_wb_rd     = wb_rd_q;
    assign o_wb_data   = wb_data_q;
    assign o_opcode    = wb_op_q;
    assign o_exc       = exc_q;
    assign o_exc_cause = cause_q;
    assign o_exc_pc    = exc_pc_q;

    assign dbus.o_wr_en      = wr_en_q;
    assign dbus.o_sel        = sel_q;
    assign dbus.o_daddr      = daddr_q;
    assign dbus.o_write_data = wdata_q;
    assign dbus.o_d_ready    = d_ready_q;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage with a WB/exception scoreboard.
module tb_mem_lsu_stage;
    import mem_lsu_stage_pkg::*;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;
    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic [XLEN-1:0]   i_result;
    logic [XLEN-1:0]   i_data_store;
    logic [ADDR_W-1:0] i_pc;
    logic [6:0]        i_opcode;
    logic [2:0]        i_func3;
    logic [4:0]        i_rd;
    logic              o_stall;
    logic [4:0]        o_ex_rd;
    logic              o_wb_valid;
    logic [4:0]        o_wb_rd;
    logic [XLEN-1:0]   o_wb_data;
    logic [6:0]        o_opcode;
    logic              o_exc;
    logic [3:0]        o_exc_cause;
    logic [ADDR_W-1:0] o_exc_pc;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        wb;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    mem_lsu_stage_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dbus ();

    mem_lsu_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_result     (i_result),
        .i_data_store (i_data_store),
        .i_pc         (i_pc),
        .i_opcode     (i_opcode),
        .i_func3      (i_func3),
        .i_rd         (i_rd),
        .o_stall      (o_stall),
        .o_ex_rd      (o_ex_rd),
        .o_wb_valid   (o_wb_valid),
        .o_wb_rd      (o_wb_rd),
        .o_wb_data    (o_wb_data),
        .o_opcode     (o_opcode),
        .o_exc        (o_exc),
        .o_exc_cause  (o_exc_cause),
        .o_exc_pc     (o_exc_pc),
        .dbus         (dbus)
    );

    function automatic void chk(input string tag, input logic ok,
                                input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdat);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdat[7:0];
            2'd1:    b = rdat[15:8];
            2'd2:    b = rdat[23:16];
            default: b = rdat[31:24];
        endcase
        h = off[1] ? rdat[31:16] : rdat[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return rdat;
        endcase
    endfunction

    function automatic void push_wb(input logic [4:0] rd, input logic [6:0] op, input logic [31:0] d);
        exp_t x;
        x = '0;
        x.wb = 1'b1; x.rd = rd; x.op = op; x.data = d;
        sb.push_back(x);
    endfunction

    function automatic void push_exc(input logic [4:0] rd, input logic [6:0] op,
                                     input logic [3:0] c, input logic [31:0] pc);
        exp_t x;
        x = '0;
        x.exc = 1'b1; x.rd = rd; x.op = op; x.cause = c; x.pc = pc;
        sb.push_back(x);
    endfunction

    // Scoreboard: every WB or exception the DUT produces must match the next expectation
    always @(negedge clk) begin
        if (!rst && (o_wb_valid || o_exc)) begin
            chk("sb_has_entry", (sb.size() != 0) === 1'b1, (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wb_valid", o_wb_valid === e.wb, o_wb_valid, e.wb);
                chk("exc", o_exc === e.exc, o_exc, e.exc);
                chk("wb_rd", o_wb_rd === e.rd, o_wb_rd, e.rd);
                chk("wb_opcode", o_opcode === e.op, o_opcode, e.op);
                if (e.exc) begin
                    chk("exc_cause", o_exc_cause === e.cause, o_exc_cause, e.cause);
                    chk("exc_pc", o_exc_pc === e.pc, o_exc_pc, e.pc);
                end else begin
                    chk("wb_data", o_wb_data === e.data, o_wb_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input logic [31:0] pc,
                          input logic [31:0] rdata, input int gap, input logic err,
                          input logic [3:0] xsel, input logic [31:0] xwdata,
                          input logic [31:0] xdata, input int xstall);
        int   stalls;
        logic st;
        st = (op == OP_S);
        i_valid = 1'b1; i_opcode = op; i_func3 = f3; i_result = addr;
        i_data_store = sdata; i_rd = rd; i_pc = pc;
        if (err)      push_exc(rd, op, st ? 4'd7 : 4'd5, pc);
        else if (!st) push_wb(rd, op, xdata);
        @(negedge clk);
        stalls = int'(o_stall);
        chk("ex_rd_issue", o_ex_rd === rd, o_ex_rd, rd);
        chk("d_ready_issue", dbus.o_d_ready === 1'b0, dbus.o_d_ready, 1'b0);
        step();
        i_valid = 1'b0; i_rd = 5'd0;
        for (int k = 0; k <= gap; k++) begin
            if (k == gap) begin
                dbus.i_d_valid = 1'b1; dbus.i_error = err; dbus.i_read_data = rdata;
            end
            @(negedge clk);
            stalls += int'(o_stall);
            chk("d_ready_wait", dbus.o_d_ready === 1'b1, dbus.o_d_ready, 1'b1);
            chk("wr_en", dbus.o_wr_en === st, dbus.o_wr_en, st);
            chk("sel", dbus.o_sel === xsel, dbus.o_sel, xsel);
            chk("daddr", dbus.o_daddr === (addr & 32'hFFFF_FFFC), dbus.o_daddr,
                (addr & 32'hFFFF_FFFC));
            chk("ex_rd_wait", o_ex_rd === rd, o_ex_rd, rd);
            if (st) chk("write_data", dbus.o_write_data === xwdata, dbus.o_write_data, xwdata);
            step();
        end
        dbus.i_d_valid = 1'b0; dbus.i_error = 1'b0; dbus.i_read_data = '0;
        @(negedge clk);
        chk("stall_cycles", stalls === xstall, stalls, xstall);
        chk("d_ready_done", dbus.o_d_ready === 1'b0, dbus.o_d_ready, 1'b0);
        chk("stall_done", o_stall === 1'b0, o_stall, 1'b0);
        chk("wb_valid_done", o_wb_valid === (!st && !err), o_wb_valid, (!st && !err));
        step();
    endtask

    task automatic misaligned(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [4:0] rd, input logic [31:0] pc, input logic [3:0] cause);
        i_valid = 1'b1; i_opcode = op; i_func3 = f3; i_result = addr;
        i_data_store = 32'h5555_AAAA; i_rd = rd; i_pc = pc;
        push_exc(rd, op, cause, pc);
        @(negedge clk);
        chk("stall_misalign", o_stall === 1'b0, o_stall, 1'b0);
        step();
        i_valid = 1'b0;
        @(negedge clk);
        chk("d_ready_misalign", dbus.o_d_ready === 1'b0, dbus.o_d_ready, 1'b0);
        chk("exc_pulse", o_exc === 1'b1, o_exc, 1'b1);
        step();
        @(negedge clk);
        chk("exc_cleared", o_exc === 1'b0, o_exc, 1'b0);
        step();
    endtask

    task automatic pass_op(input logic [31:0] res, input logic [4:0] rd);
        i_valid = 1'b1; i_opcode = OP_ADD; i_func3 = 3'b000; i_result = res; i_rd = rd;
        push_wb(rd, OP_ADD, res);
        @(negedge clk);
        chk("stall_pass", o_stall === 1'b0, o_stall, 1'b0);
        chk("ex_rd_pass", o_ex_rd === rd, o_ex_rd, rd);
        step();
        i_valid = 1'b0;
        @(negedge clk);
        chk("wb_valid_pass", o_wb_valid === 1'b1, o_wb_valid, 1'b1);
        step();
    endtask

    initial begin
        int waits;
        rst = 1'b1; i_valid = 1'b0; i_result = '0; i_data_store = '0; i_pc = '0;
        i_opcode = '0; i_func3 = '0; i_rd = '0;
        dbus.i_read_data = '0; dbus.i_d_valid = 1'b0; dbus.i_error = 1'b0;
        step(); step();
        @(negedge clk);
        chk("rst_stall", o_stall === 1'b0, o_stall, 1'b0);
        chk("rst_wb_valid", o_wb_valid === 1'b0, o_wb_valid, 1'b0);
        chk("rst_wb_data", o_wb_data === 32'h0, o_wb_data, 32'h0);
        chk("rst_exc", o_exc === 1'b0, o_exc, 1'b0);
        chk("rst_d_ready", dbus.o_d_ready === 1'b0, dbus.o_d_ready, 1'b0);
        chk("rst_sel", dbus.o_sel === 4'h0, dbus.o_sel, 4'h0);
        chk("rst_daddr", dbus.o_daddr === 32'h0, dbus.o_daddr, 32'h0);
        step();
        rst = 1'b0;

        // LW 0x100, response in the first WAIT cycle
        mem_op(OP_LD, 3'b010, 32'h100, 32'h0, 5'd5, 32'h40, 32'hDEAD_BEEF, 0, 1'b0,
               4'b1111, 32'h0, 32'hDEAD_BEEF, 2);
        // LB / LBU at 0x103
        mem_op(OP_LD, 3'b000, 32'h103, 32'h0, 5'd6, 32'h44, 32'h8012_3456, 0, 1'b0,
               4'b1000, 32'h0, 32'hFFFF_FF80, 2);
        mem_op(OP_LD, 3'b100, 32'h103, 32'h0, 5'd7, 32'h48, 32'h8012_3456, 0, 1'b0,
               4'b1000, 32'h0, 32'h0000_0080, 2);
        // LH at 0x102 with one idle WAIT cycle; LHU at 0x100
        mem_op(OP_LD, 3'b001, 32'h102, 32'h0, 5'd8, 32'h4C, 32'hF00D_1234, 1, 1'b0,
               4'b1100, 32'h0, ref_load(3'b001, 2'd2, 32'hF00D_1234), 3);
        mem_op(OP_LD, 3'b101, 32'h100, 32'h0, 5'd9, 32'h50, 32'h1111_8765, 0, 1'b0,
               4'b0011, 32'h0, ref_load(3'b101, 2'd0, 32'h1111_8765), 2);
        // SH 0x102, SB 0x101
        mem_op(OP_S, 3'b001, 32'h102, 32'h0000_ABCD, 5'd0, 32'h54, 32'h0, 0, 1'b0,
               4'b1100, 32'hABCD_ABCD, 32'h0, 2);
        mem_op(OP_S, 3'b000, 32'h101, 32'h0000_005A, 5'd0, 32'h58, 32'h0, 0, 1'b0,
               4'b0010, 32'h5A5A_5A5A, 32'h0, 2);
        // misaligned LW, SW, and LD on a 32-bit datapath
        misaligned(OP_LD, 3'b010, 32'h101, 5'd10, 32'h5C, 4'd4);
        misaligned(OP_S,  3'b010, 32'h102, 5'd11, 32'h60, 4'd6);
        misaligned(OP_LD, 3'b011, 32'h108, 5'd12, 32'h64, 4'd4);
        // SW with four idle WAIT cycles then error; LW bus error
        mem_op(OP_S, 3'b010, 32'h104, 32'h1122_3344, 5'd13, 32'h68, 32'h0, 4, 1'b1,
               4'b1111, 32'h1122_3344, 32'h0, 6);
        mem_op(OP_LD, 3'b010, 32'h108, 32'h0, 5'd14, 32'h6C, 32'h0, 1, 1'b1,
               4'b1111, 32'h0, 32'h0, 3);
        // pass-through
        pass_op(32'hCAFE_F00D, 5'd15);
        pass_op(32'h0000_0001, 5'd16);

        // reset while WAIT; a late response must be ignored
        i_valid = 1'b1; i_opcode = OP_LD; i_func3 = 3'b010; i_result = 32'h200;
        i_rd = 5'd17; i_pc = 32'h80;
        @(negedge clk);
        step();
        i_valid = 1'b0; i_rd = 5'd0;
        @(negedge clk);
        chk("d_ready_before_rst", dbus.o_d_ready === 1'b1, dbus.o_d_ready, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        dbus.i_d_valid = 1'b1; dbus.i_read_data = 32'h1234_5678;
        @(negedge clk);
        chk("rstw_d_ready", dbus.o_d_ready === 1'b0, dbus.o_d_ready, 1'b0);
        chk("rstw_stall", o_stall === 1'b0, o_stall, 1'b0);
        chk("rstw_wr_en", dbus.o_wr_en === 1'b0, dbus.o_wr_en, 1'b0);
        chk("rstw_sel", dbus.o_sel === 4'h0, dbus.o_sel, 4'h0);
        chk("rstw_daddr", dbus.o_daddr === 32'h0, dbus.o_daddr, 32'h0);
        chk("rstw_ex_rd", o_ex_rd === 5'd0, o_ex_rd, 5'd0);
        chk("rstw_wb_rd", o_wb_rd === 5'd0, o_wb_rd, 5'd0);
        chk("rstw_exc_pc", o_exc_pc === 32'h0, o_exc_pc, 32'h0);
        step();
        dbus.i_d_valid = 1'b0; dbus.i_read_data = '0;
        @(negedge clk);
        chk("late_resp_wb", o_wb_valid === 1'b0, o_wb_valid, 1'b0);
        chk("late_resp_exc", o_exc === 1'b0, o_exc, 1'b0);
        step();

`ifdef MEM_TIMEOUT_EN
        // SW that never gets a response
        i_valid = 1'b1; i_opcode = OP_S; i_func3 = 3'b010; i_result = 32'h300;
        i_data_store = 32'h0BAD_0BAD; i_rd = 5'd18; i_pc = 32'h90;
        push_exc(5'd18, OP_S, 4'd7, 32'h90);
        @(negedge clk);
        step();
        i_valid = 1'b0;
        waits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!dbus.o_d_ready) break;
            waits++;
            step();
        end
        chk("timeout_wait_cycles", waits === 4, waits, 4);
        step();
`endif

        step();
        chk("sb_drained", sb.size() === 0, sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
- Parametrised successor to the MEM pipeline stage. Sits between EX and WB.
- Adds a multi-cycle valid/ready data-memory handshake with a request FSM, byte-lane alignment, load sign/zero extension, misalignment and bus-error exceptions, and registered MEM-WB outputs.
- Raises a stall toward upstream stages while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. SEL_W = XLEN/8.
- ADDR_W, 32, data-memory address width.
- TIMEOUT, 64, maximum cycles to wait for i_d_valid. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  EX-MEM instruction valid
- i_result  in  XLEN  ALU result / effective address
- i_data_store  in  XLEN  store data
- i_pc  in  ADDR_W  instruction PC, carried to o_exc_pc
- i_opcode  in  7  opcode
- i_func3  in  3  access size/sign
- i_rd  in  5  destination register
- o_stall  out  1  hold EX-MEM and earlier stages
- o_ex_rd  out  5  rd of the instruction in MEM, for forwarding
- o_wb_valid  out  1  WB entry valid
- o_wb_rd  out  5  WB rd
- o_wb_data  out  XLEN  WB value
- o_opcode  out  7  WB opcode
- o_exc  out  1  one-cycle exception pulse
- o_exc_cause  out  4  4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault
- o_exc_pc  out  ADDR_W  faulting PC
- o_wr_en  out  1  store request
- o_sel  out  SEL_W  byte enables
- o_daddr  out  ADDR_W  word-aligned address
- o_write_data  out  XLEN  lane-shifted store data
- i_read_data  in  XLEN  read data
- o_d_ready  out  1  request active
- i_d_valid  in  1  response valid
- i_error  in  1  response error, qualified by i_d_valid

Behaviour:
- Reset (rst high at a clk edge): FSM to IDLE. All outputs 0: o_stall, o_wb_valid, o_wb_rd, o_wb_data, o_opcode, o_exc, o_exc_cause, o_exc_pc, o_ex_rd, o_d_ready, o_wr_en, o_sel, o_daddr, o_write_data.
- Reset mid-access abandons the request. o_d_ready drops the following cycle and any late i_d_valid is ignored.
- Memory op: i_valid with opcode LD (0000011) or S (0100011).
- Size from func3[1:0]: 0 = byte, 1 = half, 2 = word, 3 = double (XLEN=64 only; illegal at 32, treated as misaligned).
- func3[2] = 1 selects zero-extension.
- off = i_result[log2(SEL_W)-1:0].
- Misaligned when off is not a multiple of the access size. No bus request is issued. o_exc pulses with cause 4 or 6 next cycle; o_wb_valid = 0.
- o_sel = size mask << off. o_write_data = store data replicated across lanes. o_daddr = i_result with low off bits cleared.
- Non-memory op: single-cycle pass-through. Next cycle o_wb_valid = 1, o_wb_data = i_result. o_stall stays 0.
- FSM:
  - IDLE: on an aligned memory op, latch op/addr/rd/pc, assert o_d_ready and o_stall, go to WAIT. The same cycle the stall is combinationally high.
  - WAIT: o_d_ready, o_wr_en, o_sel, o_daddr and o_write_data held stable. o_stall = 1.
    - i_d_valid & !i_error: go to DONE. Capture read data shifted right by off×8, then sign/zero-extended.
    - i_d_valid & i_error: go to DONE with cause 5 or 7.
  - DONE: one cycle. o_d_ready = 0, o_stall = 0. Register WB outputs: o_wb_valid = 1 for loads only, or o_exc = 1. Return to IDLE.
- Latency:
  - Pass-through: 1 cycle.
  - Memory op: response cycle + 1. With i_d_valid in the first WAIT cycle, the load result appears 2 cycles after issue.
- A new i_valid while o_stall = 1 is not accepted; upstream holds it.
- o_ex_rd = latched rd while busy, else i_rd when i_valid.
- Stores produce o_wb_valid = 0.

Optional Feature:
- MEM_TIMEOUT_EN defined: a counter in WAIT counts up to TIMEOUT-1. On expiry, go to DONE with a fault cause (5 or 7) and drop o_d_ready. A response arriving in the same cycle as expiry wins over the timeout.
- Undefined: no counter; WAIT persists indefinitely.

Decomposition:
- Shared package/header (parameters.vh): opcode constants LD and S; func3 size encodings; exception cause codes; FSM state encodings.
- Sub-module mem_lsu_align (combinational): store lane shift and byte-enable generation; load extract and extension; misalign detect. Instantiated once for the request path and reused for the response.

Test Plan:
- LW addr 0x100, memory returns 0xDEADBEEF one cycle after request → o_stall high for 2 cycles; o_wb_data = 0xDEADBEEF, o_wb_valid = 1 two cycles after issue.
- LB at 0x103 with read data 0x80xxxxxx → o_sel = 4'b1000, o_wb_data = 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102 with data 0x0000ABCD → o_wr_en = 1, o_sel = 4'b1100, o_write_data = 0xABCDABCD, o_wb_valid = 0.
- LW at 0x101 → no o_d_ready; o_exc = 1 with cause 4 and o_exc_pc = i_pc next cycle.
- SW, i_d_valid held low for 5 cycles then i_d_valid & i_error → o_stall high for 6 cycles, o_exc cause 7. With MEM_TIMEOUT_EN and TIMEOUT = 4, never respond → fault cause 7 after 4 WAIT cycles.
- rst asserted in WAIT → all outputs 0 next cycle; i_d_valid arriving afterwards produces no WB and no exception.
